mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 41 ++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths, state encoding and port indices for the two-port memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  // Grant values double as port indices
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Chooses which requester wins an IDLE-cycle arbitration (fixed data priority or round robin).
// Latency: combinational; the result is registered by the caller.
// Backpressure: none; result is only meaningful while at least one request is high.
// Round robin is enabled by defining MEM_ARB_ROUND_ROBIN_EN; otherwise data port always wins a tie.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_grant,
  output logic sel_grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, favour the port that did not win last time
  always_comb begin
    sel_grant = PORT_IF;
    if (if_req && d_req) begin
      sel_grant = ~last_grant;
    end else if (d_req) begin
      sel_grant = PORT_D;
    end
  end
`else
  // History is irrelevant when the data port always wins a tie
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data port has fixed priority over instruction fetch
  always_comb begin
    sel_grant = PORT_IF;
    if (d_req) begin
      sel_grant = PORT_D;
    end
    if (!d_req && if_req) begin
      sel_grant = PORT_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory; IDLE -> ACCESS -> DONE.
// Latency: request sampled at E0, ready pulse in the cycle after edge E0+WAIT_CYCLES+1.
// Backpressure: requests are ignored outside IDLE; each requester holds req until its ready pulse.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN switches tie-breaking to round robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Winner of the previous arbitration; starts at data so fetch wins the first tie
  logic             last_grant;
  logic             sel_grant;

  mem_arb_sel u_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .sel_grant  (sel_grant)
  );

  // Main sequencer: latches the winner, counts out the memory latency, then pulses ready once
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
      busy       <= 1'b0;
      grant      <= PORT_IF;
      last_grant <= PORT_D;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            grant      <= sel_grant;
            last_grant <= sel_grant;
            cnt        <= WAIT_INIT;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            state      <= ACCESS;
            // mem_addr/mem_wdata/mem_we are the command latches, held for all of ACCESS
            if (sel_grant == PORT_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
            end else begin
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
            end
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Read data is captured even for writes; requesters simply ignore it then
            rdata  <= mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= DONE;
            if (grant == PORT_D) begin
              d_ready <= 1'b1;
            end else begin
              if_ready <= 1'b1;
            end
          end
        end

        DONE: begin
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter at WAIT_CYCLES = 1, 0 and 15.
// Reference: each accepted request occupies edges E0..E0+W as ACCESS and E0+W+1 as DONE.
// Tie-break follows MEM_ARB_ROUND_ROBIN_EN the same way the design build does.
module tb_mem_arbiter;

  localparam int NI = 3;
  localparam int WC [NI] = '{1, 0, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n     [NI];
  logic        if_req    [NI];
  logic [23:0] if_addr   [NI];
  logic        if_ready  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [23:0] d_addr    [NI];
  logic [15:0] d_wdata   [NI];
  logic        d_ready   [NI];
  logic [15:0] rdata     [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [23:0] mem_addr  [NI];
  logic [15:0] mem_wdata [NI];
  logic [15:0] mem_rdata [NI];
  logic        busy      [NI];
  logic        grant     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_arbiter #(.WAIT_CYCLES(WC[g])) u_dut (
      .clk       (clk),
      .reset_n   (rst_n[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ready  (if_ready[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ready   (d_ready[g]),
      .rdata     (rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g]),
      .grant     (grant[g])
    );
  end

  int tests = 0;
  int fails = 0;

  // Reference model state for the instance under test
  int          cur_k;
  int          W;
  int          S;          // edge at which the current access was accepted, -1 if none
  bit          sp;         // served port
  bit [23:0]   s_addr;
  bit [15:0]   s_wdata;
  bit          s_we;
  bit          last_g;
  bit          after_rst;
  bit          rst_cmd;
  bit          rand_on;
  bit          pend    [2];
  bit          hold    [2];
  bit [23:0]   p_addr  [2];
  bit [15:0]   p_wdata [2];
  bit          p_we    [2];
  int          done_at [2];
  int          served  [2];
  int          blen;
  int          nbursts;
  logic [15:0] hist [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h (cycle %0d, W=%0d)", tag, obs, exp, cyc, W);
    end
  endtask

  task automatic post_req(input int p, input bit we, input bit [23:0] addr, input bit [15:0] wd);
    pend[p]    = 1'b1;
    hold[p]    = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = addr;
    p_wdata[p] = wd;
  endtask

  task automatic select_dut(input int k);
    cur_k     = k;
    W         = WC[k];
    S         = -1;
    last_g    = 1'b1;
    after_rst = 1'b0;
    rst_cmd   = 1'b1;
    rand_on   = 1'b0;
    blen      = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; hold[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wdata[p] = '0; done_at[p] = -10;
    end
  endtask

  // One clock: decide what the arbiter accepts at the coming edge, drive, then check the cycle after it
  task automatic tick();
    int  n;
    int  k;
    bit  in_acc;
    bit  in_done;
    bit  win;
    k = cur_k;
    n = cyc;
    if (!rst_cmd) begin
      S         = -1;
      last_g    = 1'b1;
      after_rst = 1'b1;
    end else if ((S < 0 || n >= S + W + 2) && (hold[0] || hold[1])) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (hold[0] && hold[1]) win = ~last_g;
      else                    win = hold[1];
`else
      win = hold[1];
`endif
      last_g  = win;
      S       = n + 1;
      sp      = win;
      s_addr  = p_addr[win];
      s_we    = win ? p_we[1] : 1'b0;
      s_wdata = p_wdata[win];
    end
    hist[n + 1]  = 16'($urandom);
    rst_n[k]     = rst_cmd;
    if_req[k]    = hold[0];
    if_addr[k]   = p_addr[0];
    d_req[k]     = hold[1];
    d_we[k]      = p_we[1];
    d_addr[k]    = p_addr[1];
    d_wdata[k]   = p_wdata[1];
    mem_rdata[k] = hist[n + 1];

    @(negedge clk);
    n       = cyc;
    in_acc  = (S >= 0) && (n >= S) && (n <= S + W);
    in_done = (S >= 0) && (n == S + W + 1);
    chk("busy",     busy[k],     in_acc || in_done);
    chk("mem_en",   mem_en[k],   in_acc);
    chk("mem_we",   mem_we[k],   in_acc && s_we);
    chk("if_ready", if_ready[k], in_done && !sp);
    chk("d_ready",  d_ready[k],  in_done && sp);
    if (in_acc) begin
      chk("mem_addr", mem_addr[k], s_addr);
      chk("grant",    grant[k],    sp);
      if (sp) chk("mem_wdata", mem_wdata[k], s_wdata);
    end
    if (in_done) begin
      chk("rdata",      rdata[k], hist[n]);
      chk("grant_done", grant[k], sp);
    end
    if (after_rst && rst_cmd) begin
      chk("rst_mem_addr",  mem_addr[k],  0);
      chk("rst_mem_wdata", mem_wdata[k], 0);
      chk("rst_rdata",     rdata[k],     0);
      chk("rst_grant",     grant[k],     0);
      after_rst = 1'b0;
    end
    if (mem_en[k] === 1'b1) begin
      blen++;
    end else if (blen > 0) begin
      nbursts++;
      chk("burst_len", blen, W + 1);
      blen = 0;
    end

    // Requester behaviour
    if (in_done) begin
      pend[sp]    = 1'b0;
      hold[sp]    = 1'b0;
      done_at[sp] = n;
      served[sp]++;
    end
    if (rand_on && in_acc && $urandom_range(0, 5) == 0) hold[sp] = 1'b0;
    if (rand_on) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && done_at[p] != n && $urandom_range(0, 2) == 0)
          post_req(p, (p == 1) ? 1'($urandom) : 1'b0, 24'($urandom), 16'($urandom));
      end
    end
  endtask

  task automatic drain(input int maxc);
    int g;
    g = 0;
    while ((pend[0] || pend[1]) && g < maxc) begin
      tick();
      g++;
    end
    chk("drain_done", {pend[0], pend[1]}, 2'b00);
    repeat (3) tick();
  endtask

  int s0;
  int b0;
  int guard;

  initial begin
    nbursts = 0;
    served[0] = 0;
    served[1] = 0;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0;
      d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; mem_rdata[k] = 16'hA5A5;
    end
    // Reset state of every instance, with inputs held busy to show reset dominates
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      if_req[k] = 1'b1;
      d_req[k]  = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_busy",     busy[k],      0);
      chk("rst_mem_en",   mem_en[k],    0);
      chk("rst_mem_we",   mem_we[k],    0);
      chk("rst_if_ready", if_ready[k],  0);
      chk("rst_d_ready",  d_ready[k],   0);
      chk("rst_addr",     mem_addr[k],  0);
      chk("rst_wdata",    mem_wdata[k], 0);
      chk("rst_rdata",    rdata[k],     0);
      chk("rst_grant",    grant[k],     0);
      if_req[k] = 1'b0;
      d_req[k]  = 1'b0;
      rst_n[k]  = 1'b1;
    end

    // ---------------- WAIT_CYCLES = 1 ----------------
    select_dut(0);
    tick();
    post_req(0, 1'b0, 24'h002400, 16'h0000);
    repeat (6) tick();
    post_req(1, 1'b1, 24'h1F0010, 16'hBEEF);
    s0 = served[0];
    repeat (6) tick();
    chk("write_no_if_ready", served[0] - s0, 0);
    post_req(0, 1'b0, 24'h000040, 16'h0000);
    post_req(1, 1'b0, 24'h000080, 16'h1234);
    repeat (12) tick();
    chk("both_served", {pend[0], pend[1]}, 2'b00);

    // Reset pulse during the second ACCESS cycle aborts the access
    post_req(0, 1'b0, 24'h0ABCDE, 16'h0000);
    repeat (2) tick();
    chk("abort_setup_busy", busy[0], 1);
    pend[0] = 1'b0;
    hold[0] = 1'b0;
    blen    = 0;
    s0      = served[0];
    rst_cmd = 1'b0;
    tick();
    rst_cmd = 1'b1;
    repeat (8) tick();
    chk("abort_no_ready", served[0] - s0, 0);

    // Back-to-back fetches
    s0 = served[0];
    b0 = nbursts;
    for (int r = 0; r < 4; r++) begin
      post_req(0, 1'b0, 24'h000100 + 24'(r), 16'h0000);
      guard = 0;
      while (pend[0] && guard < 40) begin
        tick();
        guard++;
      end
      chk("b2b_timeout", pend[0], 0);
      tick();
    end
    tick();
    chk("b2b_accesses", nbursts - b0, 4);
    chk("b2b_readies",  served[0] - s0, 4);

    rand_on = 1'b1;
    repeat (300) tick();
    rand_on = 1'b0;
    drain(40);

    // ---------------- WAIT_CYCLES = 0 ----------------
    select_dut(1);
    tick();
    post_req(0, 1'b0, 24'h002400, 16'h0000);
    repeat (4) tick();
    post_req(1, 1'b1, 24'h1F0010, 16'hBEEF);
    post_req(0, 1'b0, 24'h000777, 16'h0000);
    repeat (8) tick();
    rand_on = 1'b1;
    repeat (200) tick();
    rand_on = 1'b0;
    drain(20);

    // ---------------- WAIT_CYCLES = 15 ----------------
    select_dut(2);
    tick();
    post_req(1, 1'b1, 24'h1F0010, 16'hBEEF);
    post_req(0, 1'b0, 24'h002400, 16'h0000);
    repeat (40) tick();
    chk("w15_both_served", {pend[0], pend[1]}, 2'b00);
    rand_on = 1'b1;
    repeat (300) tick();
    rand_on = 1'b0;
    drain(80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
